// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: single-issue FP coprocessor sequencer (IDLE -> EXEC -> WB) with sticky FCSR-style flags.
// Optional macro FP_EXC_TRAP_EN: writeback is suppressed and trap pulses on div-by-zero, sNaN or overflow.
module fp_op_sequencer #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8,
    parameter int LAT_MOV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halted,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_fs,
    input  logic [4:0]  req_ft,
    input  logic [4:0]  req_fd,
    output logic [4:0]  fs_num,
    output logic [4:0]  ft_num,
    input  logic [31:0] fs_data,
    input  logic [31:0] ft_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic [6:0]  alu_flags,
    output logic        wb_we,
    output logic [4:0]  wb_num,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        pipe_stall,
    input  logic        flags_clr,
    output logic [6:0]  fcsr_flags,
    output logic        trap
);

    localparam int LAT_MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_MAX_DM = (LAT_DIV > LAT_MOV) ? LAT_DIV : LAT_MOV;
    localparam int LAT_MAX    = (LAT_MAX_AM > LAT_MAX_DM) ? LAT_MAX_AM : LAT_MAX_DM;
    localparam int CNT_W      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [6:0]         flags_q;
    logic               accept;
    logic               exc_hit;

    // Counter preload is LAT-1 so EXEC lasts exactly LAT cycles (capture on cnt==0).
    function automatic logic [CNT_W-1:0] lat_init(input logic [1:0] op_class);
        case (op_class)
            2'b00:   lat_init = CNT_W'(LAT_ADD - 1);
            2'b01:   lat_init = CNT_W'(LAT_MUL - 1);
            2'b10:   lat_init = CNT_W'(LAT_DIV - 1);
            default: lat_init = CNT_W'(LAT_MOV - 1);
        endcase
    endfunction

`ifdef FP_EXC_TRAP_EN
    assign exc_hit = flags_q[6] | flags_q[4] | flags_q[0];
`else
    assign exc_hit = 1'b0;
`endif

    assign fs_num     = req_fs;
    assign ft_num     = req_ft;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != S_IDLE);
    assign pipe_stall = req_valid && !req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wb_we     = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !halted;
                if (req_valid && !halted) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_we   = !exc_hit;
                trap    = exc_hit;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            wb_num      <= '0;
            wb_data     <= '0;
            cnt_q       <= '0;
            flags_q     <= '0;
            fcsr_flags  <= '0;
        end else begin
            if (accept) begin
                alu_a       <= fs_data;
                alu_b       <= ft_data;
                alu_control <= req_op;
                wb_num      <= req_fd;
                cnt_q       <= lat_init(req_op[4:3]);
            end else if (state_q == S_EXEC) begin
                if (cnt_q == '0) begin
                    wb_data <= alu_result;
                    flags_q <= alu_flags;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            // A clear coinciding with WB drops the old flags but keeps the completing op's flags.
            if (state_q == S_WB) begin
                fcsr_flags <= (flags_clr ? 7'd0 : fcsr_flags) | flags_q;
            end else if (flags_clr) begin
                fcsr_flags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Testbench for fp_op_sequencer: directed table, multi-cycle corner sequences, and a randomized
// run against a timestamp-based reference model. Stub FP_ALU output varies with time to expose capture timing.
`timescale 1ns/1ps
module tb_fp_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [4:0]  req_fs;
    logic [4:0]  req_ft;
    logic [4:0]  req_fd;
    logic [4:0]  fs_num;
    logic [4:0]  ft_num;
    logic [31:0] fs_data;
    logic [31:0] ft_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_control;
    logic [31:0] alu_result;
    logic [6:0]  alu_flags;
    logic        wb_we;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        busy;
    logic        pipe_stall;
    logic        flags_clr;
    logic [6:0]  fcsr_flags;
    logic        trap;

`ifdef FP_EXC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fp_op_sequencer dut (
        .clk(clk), .rst(rst), .halted(halted),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd),
        .fs_num(fs_num), .ft_num(ft_num), .fs_data(fs_data), .ft_data(ft_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .wb_we(wb_we), .wb_num(wb_num), .wb_data(wb_data),
        .busy(busy), .pipe_stall(pipe_stall),
        .flags_clr(flags_clr), .fcsr_flags(fcsr_flags), .trap(trap)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rf [32];
    assign fs_data = rf[fs_num];
    assign ft_data = rf[ft_num];

    logic       flag_force_en;
    logic [6:0] flag_force;

    function automatic logic [31:0] alu_stub(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op, input int unsigned c);
        if (op[4:3] == 2'b00 && a == 32'h3f80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {27'd0, op} + c;
    endfunction

    function automatic logic [6:0] stub_flags(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input int unsigned c);
        logic [31:0] cv;
        cv = c;
        return a[6:0] ^ b[22:16] ^ {2'b00, op} ^ cv[6:0];
    endfunction

    function automatic int unsigned lat_of(input logic [1:0] cls);
        case (cls)
            2'b00:   return 2;
            2'b01:   return 3;
            2'b10:   return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic exc_of(input logic [6:0] f);
        return TRAP_EN && (f[6] || f[4] || f[0]);
    endfunction

    assign alu_result = alu_stub(alu_a, alu_b, alu_control, cyc);
    assign alu_flags  = flag_force_en ? flag_force : stub_flags(alu_a, alu_b, alu_control, cyc);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive point: 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] fs, input logic [4:0] ft,
                         input logic [4:0] fd, output int unsigned acc);
        req_op = op; req_fs = fs; req_ft = ft; req_fd = fd; req_valid = 1'b1;
        #2;
        check("issue_ready", 32'(req_ready), 32'd1);
        acc = cyc;
        step();
        req_valid = 1'b0;
    endtask

    // Returns sampled inside the writeback (or trap) cycle, offset relative to the accept cycle.
    task automatic wait_wb(input int unsigned acc, output int off);
        off = -1;
        for (int i = 0; i < 25; i++) begin
            #2;
            if (wb_we || trap) begin
                off = int'(cyc - acc);
                return;
            end
            step();
        end
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  fs;
        logic [4:0]  ft;
        logic [4:0]  fd;
        int          exp_off;
        logic        fixed;
        logic [31:0] data;
        logic [6:0]  flags;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    int unsigned acc;
    int          off;
    int          cnt_a;
    int          cnt_b;
    logic [6:0]  exp_fcsr;
    logic [31:0] exp_d;

    // Reference model state for the randomized phase.
    logic        m_busy;
    int unsigned m_acc;
    int unsigned m_lat;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_op;
    logic [4:0]  m_fd;
    logic [6:0]  m_fcsr;
    logic [6:0]  m_fl;
    logic [31:0] m_data;
    logic        m_exc;
    logic        m_wb;
    logic        m_ready;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'h0000_0000;
        rf[1] = 32'h3f80_0000;
        rf[2] = 32'h4000_0000;

        vt[0] = '{5'b00000, 5'd1,  5'd2,  5'd3,  3, 1'b1, 32'h4040_0000, 7'b0000000};
        vt[1] = '{5'b00001, 5'd4,  5'd5,  5'd6,  3, 1'b0, 32'h0,         7'b0001000};
        vt[2] = '{5'b01010, 5'd7,  5'd8,  5'd9,  4, 1'b0, 32'h0,         7'b0100000};
        vt[3] = '{5'b10011, 5'd10, 5'd11, 5'd12, 9, 1'b0, 32'h0,         7'b0000100};
        vt[4] = '{5'b11000, 5'd13, 5'd14, 5'd31, 2, 1'b0, 32'h0,         7'b0000010};
        vt[5] = '{5'b11111, 5'd31, 5'd0,  5'd0,  2, 1'b0, 32'h0,         7'b0000000};
        vt[6] = '{5'b01111, 5'd2,  5'd1,  5'd17, 4, 1'b0, 32'h0,         7'b0100000};

        rst = 1'b1; halted = 1'b0; req_valid = 1'b0; flags_clr = 1'b0;
        req_op = '0; req_fs = '0; req_ft = '0; req_fd = '0;
        flag_force_en = 1'b1; flag_force = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_wb_we", 32'(wb_we),       32'd0);
        check("rst_trap",  32'(trap),        32'd0);
        check("rst_alu_a", alu_a,            32'd0);
        check("rst_alu_b", alu_b,            32'd0);
        check("rst_ctrl",  32'(alu_control), 32'd0);
        check("rst_wbnum", 32'(wb_num),      32'd0);
        check("rst_wbdat", wb_data,          32'd0);
        check("rst_fcsr",  32'(fcsr_flags),  32'd0);
        rst = 1'b0;

        // Table-driven single ops (no trap-class flags, so both builds behave alike)
        exp_fcsr = '0;
        for (int i = 0; i < NV; i++) begin
            step();
            flag_force = vt[i].flags;
            issue(vt[i].op, vt[i].fs, vt[i].ft, vt[i].fd, acc);
            wait_wb(acc, off);
            check("tbl_latency", 32'(off),    32'(vt[i].exp_off));
            check("tbl_wb_num",  32'(wb_num), 32'(vt[i].fd));
            exp_d = vt[i].fixed ? vt[i].data
                  : alu_stub(rf[vt[i].fs], rf[vt[i].ft], vt[i].op, acc + 32'(vt[i].exp_off) - 1);
            check("tbl_wb_data", wb_data, exp_d);
            exp_fcsr = exp_fcsr | vt[i].flags;
            step();
            #2;
            check("tbl_fcsr", 32'(fcsr_flags), 32'(exp_fcsr));
            check("tbl_idle", 32'(busy),       32'd0);
        end

        // Reset in the middle of a divide's EXEC
        step();
        flag_force = 7'b1000000;
        issue(5'b10000, 5'd1, 5'd0, 5'd5, acc);
        step(); step(); step();
        #1 rst = 1'b1;
        #1;
        check("rstmid_busy",  32'(busy),       32'd0);
        check("rstmid_wb_we", 32'(wb_we),      32'd0);
        check("rstmid_fcsr",  32'(fcsr_flags), 32'd0);
        step();
        rst = 1'b0;
        #2;
        check("rstmid_ready", 32'(req_ready),  32'd1);
        cnt_a = 0;
        for (int r = 0; r < 12; r++) begin
            step();
            #2;
            if (wb_we || busy) cnt_a++;
        end
        check("rstmid_no_wb", 32'(cnt_a), 32'd0);
        check("rstmid_fcsr_after", 32'(fcsr_flags), 32'd0);

        // Back-to-back: divide then a held multiply
        flag_force = 7'b0000000;
        step();
        req_op = 5'b10000; req_fs = 5'd1; req_ft = 5'd2; req_fd = 5'd7; req_valid = 1'b1;
        #2;
        check("b2b_div_accept", 32'(req_ready), 32'd1);
        acc = cyc;
        step();
        req_op = 5'b01000; req_fd = 5'd8;
        cnt_a = 0; cnt_b = -1;
        for (int r = 1; r <= 9; r++) begin
            #2;
            if (pipe_stall) cnt_a++;
            if (wb_we) cnt_b = r;
            step();
        end
        check("b2b_stall_cycles", 32'(cnt_a), 32'd9);
        check("b2b_div_wb_cycle", 32'(cnt_b), 32'd9);
        #2;
        check("b2b_mul_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        wait_wb(acc, off);
        check("b2b_mul_wb_cycle", 32'(off),    32'd14);
        check("b2b_mul_wb_num",   32'(wb_num), 32'd8);

        // Sticky flags: divide by zero, then a clear coinciding with the next WB
        step();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        flag_force = 7'b1000000;
        issue(5'b10000, 5'd1, 5'd0, 5'd4, acc);
        wait_wb(acc, off);
        check("dz_wb_cycle", 32'(off), 32'd9);
        check("dz_trap",  32'(trap),  32'(TRAP_EN));
        check("dz_wb_we", 32'(wb_we), 32'(!TRAP_EN));
        step();
        #2;
        check("dz_trap_one_cycle", 32'(trap),       32'd0);
        check("dz_fcsr",           32'(fcsr_flags), 32'h40);
        step();
        flag_force = 7'b0001000;
        issue(5'b00000, 5'd4, 5'd5, 5'd6, acc);
        wait_wb(acc, off);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        #2;
        check("clr_with_wb_fcsr", 32'(fcsr_flags), 32'h08);

        // Halt raised during a multiply's EXEC
        flag_force = 7'b0000000;
        step();
        req_op = 5'b01000; req_fs = 5'd1; req_ft = 5'd2; req_fd = 5'd9; req_valid = 1'b1;
        #2;
        check("halt_mul_accept", 32'(req_ready), 32'd1);
        acc = cyc;
        step();
        halted = 1'b1;
        req_op = 5'b00000; req_fd = 5'd10;
        wait_wb(acc, off);
        check("halt_mul_wb_cycle", 32'(off),    32'd4);
        check("halt_mul_wb_we",    32'(wb_we),  32'd1);
        check("halt_mul_wb_num",   32'(wb_num), 32'd9);
        cnt_a = 0;
        for (int r = 0; r < 6; r++) begin
            step();
            #2;
            if (req_ready || !pipe_stall || busy) cnt_a++;
        end
        check("halt_blocks_accept", 32'(cnt_a), 32'd0);
        step();
        halted = 1'b0;
        #2;
        check("unhalt_accept", 32'(req_ready), 32'd1);
        acc = cyc;
        step();
        req_valid = 1'b0;
        wait_wb(acc, off);
        check("unhalt_wb_cycle", 32'(off),    32'd3);
        check("unhalt_wb_num",   32'(wb_num), 32'd10);

        // Randomized run against the reference model
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        flag_force_en = 1'b0;
        m_busy = 1'b0; m_fcsr = '0; m_acc = 0; m_lat = 0;
        m_a = '0; m_b = '0; m_op = '0; m_fd = '0;
        for (int k = 0; k < 500; k++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            halted    = ($urandom_range(0, 9) == 0);
            flags_clr = ($urandom_range(0, 19) == 0);
            req_op    = 5'($urandom_range(0, 31));
            req_fs    = 5'($urandom_range(0, 31));
            req_ft    = 5'($urandom_range(0, 31));
            req_fd    = 5'($urandom_range(0, 31));
            #2;
            m_ready = !m_busy && !halted;
            m_wb    = m_busy && (cyc == m_acc + m_lat + 1);
            m_fl    = '0;
            m_exc   = 1'b0;
            m_data  = '0;
            if (m_wb) begin
                m_data = alu_stub(m_a, m_b, m_op, m_acc + m_lat);
                m_fl   = stub_flags(m_a, m_b, m_op, m_acc + m_lat);
                m_exc  = exc_of(m_fl);
            end
            check("rnd_ready", 32'(req_ready),  32'(m_ready));
            check("rnd_busy",  32'(busy),       32'(m_busy));
            check("rnd_stall", 32'(pipe_stall), 32'(req_valid && !m_ready));
            check("rnd_wb_we", 32'(wb_we),      32'(m_wb && !m_exc));
            check("rnd_trap",  32'(trap),       32'(m_wb && m_exc));
            check("rnd_fcsr",  32'(fcsr_flags), 32'(m_fcsr));
            if (m_wb && !m_exc) begin
                check("rnd_wb_num",  32'(wb_num), 32'(m_fd));
                check("rnd_wb_data", wb_data,     m_data);
            end
            if (m_wb) begin
                m_fcsr = (flags_clr ? 7'd0 : m_fcsr) | m_fl;
                m_busy = 1'b0;
            end else if (flags_clr) begin
                m_fcsr = '0;
            end
            if (m_ready && req_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_lat  = lat_of(req_op[4:3]);
                m_a    = rf[req_fs];
                m_b    = rf[req_ft];
                m_op   = req_op;
                m_fd   = req_fd;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
